// File: rtl/main_fsm_multicycle.sv
// main_fsm_multicycle: control FSM for the multicycle RV32I datapath (fetch/decode/execute/memory/writeback).
// Define MAIN_FSM_ILLEGAL_TRAP_EN to send unknown opcodes to a sticky TRAP state that raises illegal_op.
module main_fsm_multicycle #(
  parameter bit SUPPORT_JALR  = 1'b1,
  parameter bit SUPPORT_U     = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       pc_update,
  output logic       branch,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    JALRADR  = 4'd11,
    EXECU    = 4'd12,
    TRAP     = 4'd13
  } state_t;

  typedef struct packed {
    logic       fetch;
    logic       jal;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic       done;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
  } ctrl_t;

`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
  localparam state_t UNKNOWN_NEXT = TRAP;
  logic   illegal_q;
`else
  localparam state_t UNKNOWN_NEXT = FETCH;
`endif

  state_t state_q, state_d, state_tgt;
  ctrl_t  ctrl_q, ctrl_d;
  logic   ready;

  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: if (ready) state_d = DECODE;
      DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: state_d = MEMADR;
          7'b0110011:             state_d = EXECR;
          7'b0010011:             state_d = EXECI;
          7'b1100011:             state_d = BEQ;
          7'b1101111:             state_d = JAL;
          7'b1100111: begin
            if (SUPPORT_JALR) state_d = JALRADR;
            else              state_d = UNKNOWN_NEXT;
          end
          7'b0110111, 7'b0010111: begin
            if (SUPPORT_U) state_d = EXECU;
            else           state_d = UNKNOWN_NEXT;
          end
          default:                state_d = UNKNOWN_NEXT;
        endcase
      end
      MEMADR: begin
        if (op[5]) state_d = MEMWRITE;
        else       state_d = MEMREAD;
      end
      MEMREAD:               if (ready) state_d = MEMWB;
      MEMWRITE:              if (ready) state_d = FETCH;
      MEMWB, ALUWB, BEQ:     state_d = FETCH;
      EXECR, EXECI, EXECU:   state_d = ALUWB;
      JALRADR:               state_d = JAL;
      JAL:                   state_d = ALUWB;
      TRAP:                  state_d = TRAP;
      default:               state_d = FETCH;
    endcase
  end

  // Moore outputs are decoded from the state about to be entered so they are
  // registered alongside state_q; EXECU samples op while still in DECODE.
  always_comb begin
    state_tgt = reset ? FETCH : state_d;
    ctrl_d    = '0;
    case (state_tgt)
      FETCH: begin
        ctrl_d.fetch      = 1'b1;
        ctrl_d.alu_src_b  = 2'b10;
        ctrl_d.result_src = 2'b10;
      end
      DECODE: begin
        ctrl_d.alu_src_a = 2'b01;
        ctrl_d.alu_src_b = 2'b01;
      end
      MEMADR: begin
        ctrl_d.alu_src_a = 2'b10;
        ctrl_d.alu_src_b = 2'b01;
      end
      MEMREAD: ctrl_d.adr_src = 1'b1;
      MEMWB: begin
        ctrl_d.result_src = 2'b01;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.done       = 1'b1;
      end
      MEMWRITE: begin
        ctrl_d.adr_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      EXECR: begin
        ctrl_d.alu_src_a = 2'b10;
        ctrl_d.alu_op    = 2'b10;
      end
      EXECI: begin
        ctrl_d.alu_src_a = 2'b10;
        ctrl_d.alu_src_b = 2'b01;
        ctrl_d.alu_op    = 2'b10;
      end
      EXECU: begin
        ctrl_d.alu_src_a = op[5] ? 2'b11 : 2'b01;
        ctrl_d.alu_src_b = 2'b01;
      end
      ALUWB: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.done      = 1'b1;
      end
      BEQ: begin
        ctrl_d.alu_src_a = 2'b10;
        ctrl_d.alu_op    = 2'b01;
        ctrl_d.branch    = 1'b1;
        ctrl_d.done      = 1'b1;
      end
      JALRADR: begin
        ctrl_d.alu_src_a = 2'b10;
        ctrl_d.alu_src_b = 2'b01;
      end
      JAL: begin
        ctrl_d.alu_src_a = 2'b01;
        ctrl_d.alu_src_b = 2'b10;
        ctrl_d.jal       = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      ctrl_q    <= ctrl_d;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      if (state_d == TRAP) illegal_q <= 1'b1;
`endif
    end
  end

`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  always_comb begin
    case (op)
      7'b0100011:             imm_src = 3'b001;
      7'b1100011:             imm_src = 3'b010;
      7'b1101111:             imm_src = 3'b011;
      7'b0110111, 7'b0010111: imm_src = 3'b100;
      default:                imm_src = 3'b000;
    endcase
  end

  // Write-type enables are masked by reset so an abandoned instruction never commits.
  assign pc_update  = ~reset & ((ctrl_q.fetch & ready) | ctrl_q.jal);
  assign ir_write   = ~reset & ctrl_q.fetch & ready;
  assign reg_write  = ~reset & ctrl_q.reg_write;
  assign mem_write  = ~reset & ctrl_q.mem_write;
  assign instr_done = ~reset & (ctrl_q.done | (ctrl_q.mem_write & ready));
  assign branch     = ctrl_q.branch;
  assign adr_src    = ctrl_q.adr_src;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign result_src = ctrl_q.result_src;
  assign alu_op     = ctrl_q.alu_op;
  assign state      = state_q;

endmodule

// File: tb/tb_main_fsm_multicycle.sv
// tb_main_fsm_multicycle: directed checks of the multicycle control FSM, one task per scenario.
// Trap expectations follow MAIN_FSM_ILLEGAL_TRAP_EN when the bench is built with that macro.
module tb_main_fsm_multicycle;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       mem_ready;

  logic       pc_update, branch, ir_write, reg_write, mem_write, adr_src;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic [2:0] imm_src;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  logic       nj_pc_update, nj_branch, nj_ir_write, nj_reg_write, nj_mem_write, nj_adr_src;
  logic [1:0] nj_alu_src_a, nj_alu_src_b, nj_result_src, nj_alu_op;
  logic [2:0] nj_imm_src;
  logic       nj_instr_done, nj_illegal_op;
  logic [3:0] nj_state;

  int total = 0;
  int bad   = 0;

  main_fsm_multicycle dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pc_update(pc_update), .branch(branch), .ir_write(ir_write),
    .reg_write(reg_write), .mem_write(mem_write), .adr_src(adr_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_op(alu_op), .imm_src(imm_src), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state)
  );

  main_fsm_multicycle #(
    .SUPPORT_JALR(1'b0), .SUPPORT_U(1'b0), .MEM_HANDSHAKE(1'b0)
  ) dut_nj (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pc_update(nj_pc_update), .branch(nj_branch), .ir_write(nj_ir_write),
    .reg_write(nj_reg_write), .mem_write(nj_mem_write), .adr_src(nj_adr_src),
    .alu_src_a(nj_alu_src_a), .alu_src_b(nj_alu_src_b), .result_src(nj_result_src),
    .alu_op(nj_alu_op), .imm_src(nj_imm_src), .instr_done(nj_instr_done),
    .illegal_op(nj_illegal_op), .state(nj_state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; op = 7'b0000000;
    tick(); tick();
    #1;
    total++; if (state !== 4'd0) begin bad++; $display("FAIL rst_state got %0d want 0", state); end
    total++; if (pc_update !== 1'b0) begin bad++; $display("FAIL rst_pc_update got %b want 0", pc_update); end
    total++; if (ir_write !== 1'b0) begin bad++; $display("FAIL rst_ir_write got %b want 0", ir_write); end
    total++; if (instr_done !== 1'b0) begin bad++; $display("FAIL rst_instr_done got %b want 0", instr_done); end
    total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL rst_illegal got %b want 0", illegal_op); end
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    total++; if (ir_write !== 1'b0) begin bad++; $display("FAIL fetch_noready_ir got %b want 0", ir_write); end
    total++; if ({adr_src, alu_src_a, alu_src_b, alu_op, result_src} !== 9'b0_00_10_00_10)
      begin bad++; $display("FAIL fetch_ctrl got %b want 000100010", {adr_src, alu_src_a, alu_src_b, alu_op, result_src}); end
    mem_ready = 1'b1;
    #1;
    total++; if ({ir_write, pc_update} !== 2'b11) begin bad++; $display("FAIL fetch_ready_en got %b want 11", {ir_write, pc_update}); end
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_lw();
    int         exp_st[8] = '{0, 0, 0, 1, 2, 3, 3, 4};
    logic [7:0] rdy = 8'b0101_1100;
    int         dones = 0;
    op = 7'b0000011;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      #1;
      total++; if (state !== 4'(exp_st[i])) begin bad++; $display("FAIL lw_state[%0d] got %0d want %0d", i, state, exp_st[i]); end
      total++; if (reg_write !== (i == 7)) begin bad++; $display("FAIL lw_reg_write[%0d] got %b want %b", i, reg_write, (i == 7)); end
      total++; if (ir_write !== (i == 2)) begin bad++; $display("FAIL lw_ir_write[%0d] got %b want %b", i, ir_write, (i == 2)); end
      if (i == 5 || i == 6) begin
        total++; if (adr_src !== 1'b1) begin bad++; $display("FAIL lw_adr_src[%0d] got %b want 1", i, adr_src); end
      end
      if (i == 7) begin
        total++; if (result_src !== 2'b01) begin bad++; $display("FAIL lw_result_src got %b want 01", result_src); end
      end
      dones += int'(instr_done);
      tick();
    end
    total++; if (dones != 1) begin bad++; $display("FAIL lw_done_count got %0d want 1", dones); end
    total++; if (state !== 4'd0) begin bad++; $display("FAIL lw_end_state got %0d want 0", state); end
  endtask

  task automatic test_sw();
    int exp_st[4] = '{0, 1, 2, 5};
    op = 7'b0100011; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (state !== 4'(exp_st[i])) begin bad++; $display("FAIL sw_state[%0d] got %0d want %0d", i, state, exp_st[i]); end
      total++; if (mem_write !== (i == 3)) begin bad++; $display("FAIL sw_mem_write[%0d] got %b want %b", i, mem_write, (i == 3)); end
      total++; if (instr_done !== (i == 3)) begin bad++; $display("FAIL sw_done[%0d] got %b want %b", i, instr_done, (i == 3)); end
      total++; if (imm_src !== 3'b001) begin bad++; $display("FAIL sw_imm_src[%0d] got %b want 001", i, imm_src); end
      tick();
    end
    total++; if (state !== 4'd0) begin bad++; $display("FAIL sw_end_state got %0d want 0", state); end
  endtask

  task automatic test_back_to_back();
    int exp_st[11]  = '{0, 1, 6, 8, 0, 1, 7, 8, 0, 1, 9};
    int exp_aop[11] = '{0, 0, 2, 0, 0, 0, 2, 0, 0, 0, 1};
    int exp_asa[11] = '{0, 1, 2, 0, 0, 1, 2, 0, 0, 1, 2};
    logic [10:0] exp_done = 11'b100_1000_1000;
    mem_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      op = (i < 4) ? 7'b0110011 : (i < 8) ? 7'b0010011 : 7'b1100011;
      #1;
      total++; if (state !== 4'(exp_st[i])) begin bad++; $display("FAIL b2b_state[%0d] got %0d want %0d", i, state, exp_st[i]); end
      total++; if (alu_op !== 2'(exp_aop[i])) begin bad++; $display("FAIL b2b_alu_op[%0d] got %b want %0d", i, alu_op, exp_aop[i]); end
      total++; if (alu_src_a !== 2'(exp_asa[i])) begin bad++; $display("FAIL b2b_alu_src_a[%0d] got %b want %0d", i, alu_src_a, exp_asa[i]); end
      total++; if (branch !== (i == 10)) begin bad++; $display("FAIL b2b_branch[%0d] got %b want %b", i, branch, (i == 10)); end
      total++; if (instr_done !== exp_done[i]) begin bad++; $display("FAIL b2b_done[%0d] got %b want %b", i, instr_done, exp_done[i]); end
      tick();
    end
    total++; if (state !== 4'd0) begin bad++; $display("FAIL b2b_end_state got %0d want 0", state); end
  endtask

  task automatic test_jal_jalr();
    int exp_st[9]  = '{0, 1, 10, 8, 0, 1, 11, 10, 8};
    int exp_asa[9] = '{0, 1, 1, 0, 0, 1, 2, 1, 0};
    int exp_imm[9] = '{3, 3, 3, 3, 0, 0, 0, 0, 0};
    logic [8:0] exp_pc = 9'b0_1001_0101;
    logic [8:0] exp_rw = 9'b1_0000_1000;
    mem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      op = (i < 4) ? 7'b1101111 : 7'b1100111;
      #1;
      total++; if (state !== 4'(exp_st[i])) begin bad++; $display("FAIL jal_state[%0d] got %0d want %0d", i, state, exp_st[i]); end
      total++; if (pc_update !== exp_pc[i]) begin bad++; $display("FAIL jal_pc_update[%0d] got %b want %b", i, pc_update, exp_pc[i]); end
      total++; if (reg_write !== exp_rw[i]) begin bad++; $display("FAIL jal_reg_write[%0d] got %b want %b", i, reg_write, exp_rw[i]); end
      total++; if (alu_src_a !== 2'(exp_asa[i])) begin bad++; $display("FAIL jal_alu_src_a[%0d] got %b want %0d", i, alu_src_a, exp_asa[i]); end
      total++; if (imm_src !== 3'(exp_imm[i])) begin bad++; $display("FAIL jal_imm_src[%0d] got %b want %0d", i, imm_src, exp_imm[i]); end
      tick();
    end
  endtask

  task automatic test_upper();
    int exp_st[8]  = '{0, 1, 12, 8, 0, 1, 12, 8};
    int exp_asa[8] = '{0, 1, 3, 0, 0, 1, 1, 0};
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = (i < 4) ? 7'b0110111 : 7'b0010111;
      #1;
      total++; if (state !== 4'(exp_st[i])) begin bad++; $display("FAIL u_state[%0d] got %0d want %0d", i, state, exp_st[i]); end
      total++; if (alu_src_a !== 2'(exp_asa[i])) begin bad++; $display("FAIL u_alu_src_a[%0d] got %b want %0d", i, alu_src_a, exp_asa[i]); end
      total++; if (imm_src !== 3'b100) begin bad++; $display("FAIL u_imm_src[%0d] got %b want 100", i, imm_src); end
      tick();
    end
  endtask

  task automatic test_params();
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    int exp_st[5] = '{0, 1, 13, 13, 13};
    logic exp_ill = 1'b1;
`else
    int exp_st[5] = '{0, 1, 0, 1, 0};
    logic exp_ill = 1'b0;
`endif
    reset = 1'b1; mem_ready = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      op = (i < 2) ? 7'b1100111 : 7'b0110111;
      #1;
      total++; if (nj_state !== 4'(exp_st[i])) begin bad++; $display("FAIL nj_state[%0d] got %0d want %0d", i, nj_state, exp_st[i]); end
      total++; if (nj_instr_done !== 1'b0) begin bad++; $display("FAIL nj_done[%0d] got %b want 0", i, nj_instr_done); end
      total++; if (state !== 4'd0) begin bad++; $display("FAIL stall_state[%0d] got %0d want 0", i, state); end
      if (i == 0) begin
        total++; if (nj_ir_write !== 1'b1) begin bad++; $display("FAIL nj_ir_write got %b want 1", nj_ir_write); end
      end
      tick();
    end
    total++; if (nj_illegal_op !== exp_ill) begin bad++; $display("FAIL nj_illegal got %b want %b", nj_illegal_op, exp_ill); end
  endtask

  task automatic test_illegal();
    op = 7'b1111111; mem_ready = 1'b1;
    #1;
    total++; if (state !== 4'd0) begin bad++; $display("FAIL ill_fetch_state got %0d want 0", state); end
    tick();
    #1;
    total++; if (state !== 4'd1) begin bad++; $display("FAIL ill_decode_state got %0d want 1", state); end
    total++; if (instr_done !== 1'b0) begin bad++; $display("FAIL ill_decode_done got %b want 0", instr_done); end
    tick();
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      #1;
      total++; if (state !== 4'd13) begin bad++; $display("FAIL trap_state[%0d] got %0d want 13", i, state); end
      total++; if (illegal_op !== 1'b1) begin bad++; $display("FAIL trap_illegal[%0d] got %b want 1", i, illegal_op); end
      total++; if ({pc_update, ir_write, reg_write, mem_write, instr_done} !== 5'b0)
        begin bad++; $display("FAIL trap_enables[%0d] got %b want 00000", i, {pc_update, ir_write, reg_write, mem_write, instr_done}); end
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    total++; if (state !== 4'd0) begin bad++; $display("FAIL trap_rst_state got %0d want 0", state); end
    total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL trap_rst_illegal got %b want 0", illegal_op); end
`else
    mem_ready = 1'b0;
    #1;
    total++; if (state !== 4'd0) begin bad++; $display("FAIL nop_state got %0d want 0", state); end
    total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL nop_illegal got %b want 0", illegal_op); end
`endif
    tick();
  endtask

  task automatic test_reset_memwrite();
    int exp_st[4] = '{0, 1, 2, 5};
    op = 7'b0100011;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 0);
      #1;
      total++; if (state !== 4'(exp_st[i])) begin bad++; $display("FAIL rmw_state[%0d] got %0d want %0d", i, state, exp_st[i]); end
      tick();
    end
    #1;
    total++; if ({state, mem_write, instr_done} !== 6'b0101_10) begin bad++; $display("FAIL rmw_hold got %b want 010110", {state, mem_write, instr_done}); end
    reset = 1'b1;
    #1;
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL rmw_reset_mem_write got %b want 0", mem_write); end
    total++; if (instr_done !== 1'b0) begin bad++; $display("FAIL rmw_reset_done got %b want 0", instr_done); end
    tick();
    reset = 1'b0;
    #1;
    total++; if (state !== 4'd0) begin bad++; $display("FAIL rmw_after_state got %0d want 0", state); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_back_to_back();
    test_jal_jalr();
    test_upper();
    test_params();
    test_illegal();
    test_reset_memwrite();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
